muldiv_seq_ctrl: RTL and testbench
==================================

// Module: muldiv_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and owner of the architectural HI/LO pair.
//  Replaces the single-cycle combinational * / % path in the ALU with a radix-2 iterative engine.
//  Exposes start/busy/done so the pipeline stalls on a later access (MFHI/MFLO, or a new mul/div).
//  Sits beside the ALU in EX; MTHI/MTLO writes and MFHI/MFLO reads go through this block.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are each WIDTH bits; the engine runs WIDTH iterations
// PORTS
//  clk      in   1      clock, rising edge
//  reset_n  in   1      asynchronous reset, active-low
//  start    in   1      launch an operation; sampled only when busy=0
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a        in   WIDTH  rs operand: multiplicand or dividend
//  b        in   WIDTH  rt operand: multiplier or divisor
//  flush    in   1      abort the operation in flight; HI/LO are left unchanged
//  mthi     in   1      write wdata to HI; honoured only when busy=0
//  mtlo     in   1      write wdata to LO; honoured only when busy=0
//  wdata    in   WIDTH  MTHI/MTLO data
//  busy     out  1      operation in progress (PREP, CALC or FIX state)
//  done     out  1      one-cycle pulse; hi/lo hold the new result in this cycle
//  hi       out  WIDTH  HI register: product high half or remainder
//  lo       out  WIDTH  LO register: product low half or quotient
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, all operand latches=0.
//    Reset is asynchronous and takes effect mid-operation: the result is discarded and no done pulse follows.
//  FSM states: IDLE, PREP, CALC, FIX, DONE.
//    IDLE/DONE + start  -> PREP: latch op, a, b.
//    IDLE/DONE, no start -> IDLE.
//    PREP -> CALC: take absolute values for signed ops, record sign(a) and sign(a)^sign(b), clear counter.
//    CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle.
//      Stay in CALC for WIDTH cycles; counter counts 0..WIDTH-1; leave to FIX at counter==WIDTH-1.
//    FIX -> DONE: apply sign correction and write hi/lo.
//    DONE asserts done=1 for exactly one cycle, with busy=0.
//  Latency: start sampled at edge 0; done=1 in the cycle after edge WIDTH+2, i.e. 35 cycles for WIDTH=32.
//    hi/lo are valid from that cycle on and hold until the next write.
//  A start in the DONE cycle is accepted, so back-to-back ops have no bubble.
//  start while busy=1 is ignored; it is neither queued nor an error.
//  flush: honoured in any busy state -> IDLE on the next edge.
//    No done pulse; hi/lo unchanged. flush in IDLE/DONE has no effect.
//    flush and start in the same cycle: flush wins, and start is dropped.
//  mthi/mtlo while busy=1 are ignored.
//    When busy=0 they write on the edge. If start is also asserted, the write happens and the later result overwrites it.
//  Mul results: the full 2*WIDTH product goes to {hi,lo}.
//    Signed: negate the product if sign(a)^sign(b). Unsigned: plain product.
//  Div results: lo=quotient, hi=remainder; signed division truncates toward zero.
//    The remainder takes the sign of the dividend.
//  Divide by zero, any div op: lo={WIDTH{1'b1}}, hi=a (raw dividend); latency unchanged.
//  Signed overflow, DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0; no flag raised.
//  No combinational path from any input to busy/done/hi/lo; all outputs are registered.
// TESTING
//  1 MULT a=0xFFFFFFFD(-3) b=5 -> done at cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy=1 in cycles 1..34.
//  2 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  3 DIVU 100/7 -> lo=14, hi=2. Then DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    The DIV is started in the DONE cycle of the DIVU, so there is no idle gap.
//  4 DIV a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678.
//    Also DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  5 MTHI 0xAAAA, then MULT started; flush at cycle 10 -> busy=0 at cycle 11, no done, hi=0xAAAA.
//    A second start at cycle 10 (during the flush) is ignored.
//  6 reset_n low at cycle 20 of a DIVU -> busy/done/hi/lo=0 immediately, no done pulse.
//    Also: start and mtlo while busy are ignored, and lo keeps the pending op's result.

Source files
------------

// File: rtl/muldiv_seq_ctrl.sv
// Iterative radix-2 multiply/divide sequencer owning the architectural HI/LO pair.
// One shift-add or restoring shift-subtract step per cycle; WIDTH steps per operation.
module muldiv_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW       = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_busy_nxt;
  logic             w_busy_st;
  logic             w_accept;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_ph;
  logic [WIDTH-1:0] r_pl;
  logic [CW-1:0]    r_cnt;
  logic             r_sgn_a;
  logic             r_sgn_x;

  logic             w_is_div;
  logic             w_signed;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [PW-1:0]    w_prod;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  assign w_busy_st = (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);
  assign w_accept  = start && !w_busy_st;
  assign w_is_div  = r_op[1];
  assign w_signed  = !r_op[0];

  // Next-state logic; flush aborts any busy state and swallows a coincident start.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: w_state_nxt = w_accept ? S_PREP : S_IDLE;
      S_PREP:         w_state_nxt = S_CALC;
      S_CALC:         w_state_nxt = (r_cnt == CNT_LAST) ? S_FIX : S_CALC;
      S_FIX:          w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
    if (flush && w_busy_st) begin
      w_state_nxt = S_IDLE;
    end
    w_busy_nxt = (w_state_nxt == S_PREP) || (w_state_nxt == S_CALC) ||
                 (w_state_nxt == S_FIX);
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Magnitudes of the latched operands for signed ops.
  always_comb begin
    w_a_abs = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    w_b_abs = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;
  end

  // Single iteration step: r_pl holds multiplier bits / dividend bits, r_ph the running high part.
  always_comb begin
    w_mul_sum = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_d} : {(WIDTH+1){1'b0}});
    w_div_sh  = {r_ph, r_pl[WIDTH-1]};
    w_div_ge  = (w_div_sh >= {1'b0, r_d});
    w_div_rem = WIDTH'(w_div_sh - {1'b0, r_d});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= 2'b00;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_ph    <= '0;
      r_pl    <= '0;
      r_cnt   <= '0;
      r_sgn_a <= 1'b0;
      r_sgn_x <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
          end
        end
        S_PREP: begin
          r_sgn_a <= w_signed && r_a[WIDTH-1];
          r_sgn_x <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_pl    <= w_a_abs;
          r_d     <= w_b_abs;
          r_ph    <= '0;
          r_cnt   <= '0;
        end
        S_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_is_div) begin
            r_ph <= w_div_ge ? w_div_rem : w_div_sh[WIDTH-1:0];
            r_pl <= {r_pl[WIDTH-2:0], w_div_ge};
          end else begin
            r_ph <= w_mul_sum[WIDTH:1];
            r_pl <= {w_mul_sum[0], r_pl[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Sign correction and the divide-by-zero convention applied in FIX.
  always_comb begin
    w_prod   = {r_ph, r_pl};
    w_fix_hi = '0;
    w_fix_lo = '0;
    if (!w_is_div) begin
      if (r_sgn_x) begin
        w_prod = -w_prod;
      end
      w_fix_hi = w_prod[PW-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end else if (r_b == '0) begin
      w_fix_hi = r_a;
      w_fix_lo = '1;
    end else begin
      w_fix_hi = r_sgn_a ? -r_ph : r_ph;
      w_fix_lo = r_sgn_x ? -r_pl : r_pl;
    end
  end

  // HI/LO: results land from FIX; MTHI/MTLO only while not busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      if (!flush) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end else if (!w_busy_st) begin
      if (mthi) r_hi <= wdata;
      if (mtlo) r_lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Scoreboard bench for muldiv_seq_ctrl: directed cases plus randomized ops checked
// against a plain-arithmetic model; a separate monitor checks every done pulse.
module tb_muldiv_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] exp;
    int          t0;
  } sb_t;
  sb_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: {hi,lo} from MIPS mul/div rules using 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint          sx = $signed(x);
    longint          sy = $signed(y);
    longint unsigned ux = {32'h0, x};
    longint unsigned uy = {32'h0, y};
    longint          q;
    longint          r;
    logic [63:0]     res;
    case (o)
      2'd0: res = sx * sy;
      2'd1: res = ux * uy;
      default: begin
        if (y == 32'h0) begin
          res = {x, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
          q   = sx / sy;
          r   = sx % sy;
          res = {r[31:0], q[31:0]};
        end else begin
          q   = longint'(ux / uy);
          r   = longint'(ux % uy);
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Monitor: every done pulse must match the oldest expected result and timing.
  initial begin
    int  run;
    sb_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("busy_in_done", {63'h0, busy}, 64'h0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("hi", {32'h0, hi}, {32'h0, e.exp[63:32]});
          chk("lo", {32'h0, lo}, {32'h0, e.exp[31:0]});
          chk("latency", 64'(cyc - e.t0), 64'd34);
          chk("busy_cycles", 64'(run), 64'd34);
        end
        run = 0;
      end else if (busy) begin
        run++;
      end else begin
        run = 0;
      end
    end
  end

  // Drive a start at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push);
    sb_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (push) begin
      e.exp = model(o, x, y);
      e.t0  = cyc;
      sbq.push_back(e);
    end
  endtask

  // Bounded wait; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({"done_seen_", tag}, {63'h0, done}, 64'h1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    logic [1:0]  o;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: MULT -3 * 5
    issue(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done("mult");
    chk("t1_hi", {32'h0, hi}, 64'hFFFF_FFFF);
    chk("t1_lo", {32'h0, lo}, 64'hFFFF_FFF1);
    @(negedge clk);

    // 2: MULTU max * max
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("multu");
    chk("t2_hi", {32'h0, hi}, 64'hFFFF_FFFE);
    chk("t2_lo", {32'h0, lo}, 64'h1);
    @(negedge clk);

    // 3: DIVU 100/7, then DIV -7/2 launched in the DONE cycle
    issue(2'd3, 32'd100, 32'd7, 1'b1);
    wait_done("divu");
    chk("t3_lo", {32'h0, lo}, 64'd14);
    chk("t3_hi", {32'h0, hi}, 64'd2);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("div_b2b");
    chk("t3b_lo", {32'h0, lo}, 64'hFFFF_FFFD);
    chk("t3b_hi", {32'h0, hi}, 64'hFFFF_FFFF);
    @(negedge clk);

    // 4: divide by zero and signed overflow
    issue(2'd2, 32'h1234_5678, 32'h0, 1'b1);
    wait_done("div0");
    chk("t4_lo", {32'h0, lo}, 64'hFFFF_FFFF);
    chk("t4_hi", {32'h0, hi}, 64'h1234_5678);
    @(negedge clk);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_ovf");
    chk("t4b_lo", {32'h0, lo}, 64'h8000_0000);
    chk("t4b_hi", {32'h0, hi}, 64'h0);
    @(negedge clk);

    // 5: MTHI/MTLO, then a MULT flushed at cycle 10 with a competing start
    mthi = 1'b1;
    wdata = 32'h0000_AAAA;
    @(negedge clk);
    mthi = 1'b0;
    chk("t5_mthi", {32'h0, hi}, 64'hAAAA);
    mtlo = 1'b1;
    wdata = 32'h0000_5555;
    @(negedge clk);
    mtlo = 1'b0;
    chk("t5_mtlo", {32'h0, lo}, 64'h5555);
    issue(2'd0, 32'd1234, 32'd5678, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    op = 2'd1;
    a = 32'd3;
    b = 32'd3;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("t5_busy", {63'h0, busy}, 64'h0);
    chk("t5_done", {63'h0, done}, 64'h0);
    chk("t5_hi", {32'h0, hi}, 64'hAAAA);
    chk("t5_lo", {32'h0, lo}, 64'h5555);
    repeat (40) @(negedge clk);
    chk("t5_busy_late", {63'h0, busy}, 64'h0);
    chk("t5_hi_late", {32'h0, hi}, 64'hAAAA);

    // 6a: start and mtlo while busy are ignored
    issue(2'd3, 32'd1000, 32'd9, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op = 2'd0;
    a = 32'd7;
    b = 32'd7;
    mtlo = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    mtlo = 1'b0;
    wait_done("busy_ign");
    chk("t6_lo", {32'h0, lo}, 64'd111);
    chk("t6_hi", {32'h0, hi}, 64'd1);
    repeat (40) @(negedge clk);
    chk("t6_lo_late", {32'h0, lo}, 64'd111);

    // Randomized ops, mixing back-to-back launches and MTHI/MTLO alongside start
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick();
      y = pick();
      if (i == 0 || $urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      mthi = 1'($urandom_range(0, 1));
      mtlo = 1'($urandom_range(0, 1));
      wdata = $urandom;
      issue(o, x, y, 1'b1);
      mthi = 1'b0;
      mtlo = 1'b0;
      wait_done("rand");
    end
    @(negedge clk);

    // 6b: asynchronous reset mid DIVU
    issue(2'd3, 32'hCAFE_F00D, 32'd13, 1'b0);
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6b_busy", {63'h0, busy}, 64'h0);
    chk("t6b_done", {63'h0, done}, 64'h0);
    chk("t6b_hi", {32'h0, hi}, 64'h0);
    chk("t6b_lo", {32'h0, lo}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("t6b_busy_late", {63'h0, busy}, 64'h0);
    chk("t6b_lo_late", {32'h0, lo}, 64'h0);

    chk("sb_empty", 64'(sbq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
